mem_arbiter: RTL and testbench

- Shares one SRAM-like memory master port between the instruction-fetch requester (read-only) and the data requester (load/store).
- Translates each granted virtual address to a physical address with the existing mmu mapper, and flags kseg1 accesses as uncached.
- Sits between the CPU core's fetch/mem stages and the memory/cache interface.
- Allows exactly one outstanding transaction at a time.

---
 rtl/mem_arbiter_pkg.sv | 23 ++
 rtl/mem_arbiter_if.sv | 52 +++++
 rtl/mem_arbiter_mmu.sv | 25 ++
 rtl/mem_arbiter.sv | 119 +++++++++++
 tb/tb_mem_arbiter.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared codes for the fetch/data memory arbiter
// Holds segment codes, access size codes, FSM state and owner encodings.
package mem_arbiter_pkg;

    localparam logic [2:0] SEG_KSEG0 = 3'b100;
    localparam logic [2:0] SEG_KSEG1 = 3'b101;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch, load/store and memory bus signals of the arbiter
// slave  : arbiter view (requests in, addr_ok/data_ok/rdata out, mem_* out, mem responses in)
// master : environment view (core requesters and memory model)
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  inst_req;
    logic [ADDR_W-1:0]     inst_addr;
    logic                  inst_addr_ok;
    logic                  inst_data_ok;
    logic [DATA_W-1:0]     inst_rdata;

    logic                  data_req;
    logic                  data_wr;
    logic [1:0]            data_size;
    logic [DATA_W/8-1:0]   data_wstrb;
    logic [ADDR_W-1:0]     data_addr;
    logic [DATA_W-1:0]     data_wdata;
    logic                  data_addr_ok;
    logic                  data_data_ok;
    logic [DATA_W-1:0]     data_rdata;

    logic                  mem_req;
    logic                  mem_wr;
    logic [1:0]            mem_size;
    logic [DATA_W/8-1:0]   mem_wstrb;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic                  mem_uncached;
    logic                  mem_addr_ok;
    logic                  mem_data_ok;
    logic [DATA_W-1:0]     mem_rdata;

    modport slave (
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata, mem_uncached,
        input  mem_addr_ok, mem_data_ok, mem_rdata
    );

    modport master (
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata, mem_uncached,
        output mem_addr_ok, mem_data_ok, mem_rdata
    );
endinterface

// File: rtl/mem_arbiter_mmu.sv
// rtl/mem_arbiter_mmu.sv - fixed-mapping virtual to physical address translator
// i_vaddr    : virtual address
// o_paddr    : physical address (kseg0/kseg1 fold onto the low 512 MB)
// o_uncached : virtual address lies in kseg1
module mem_arbiter_mmu
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] i_vaddr,
    output logic [ADDR_W-1:0] o_paddr,
    output logic              o_uncached
);
    logic [2:0] w_seg;

    assign w_seg      = i_vaddr[ADDR_W-1 -: 3];
    assign o_uncached = (w_seg == SEG_KSEG1);

    always_comb begin
        o_paddr = i_vaddr;
        if (w_seg == SEG_KSEG0 || w_seg == SEG_KSEG1) begin
            o_paddr = {3'b000, i_vaddr[ADDR_W-4:0]};
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one memory port between fetch and load/store requesters
// clk : system clock
// rst : asynchronous active-high reset
// bus : fetch, load/store and memory signals (slave modport)
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    import mem_arbiter_pkg::*;

    state_t              r_state;
    owner_t              r_owner;
    owner_t              r_last_grant;
    logic                r_mem_req;
    logic                r_wr;
    logic [1:0]          r_size;
    logic [DATA_W/8-1:0] r_wstrb;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_uncached;

    logic                w_grant_inst;
    logic                w_grant_data;
    logic                w_idle;
    logic                w_resp_inst;
    logic                w_resp_data;
    logic [ADDR_W-1:0]   w_vaddr;
    logic [ADDR_W-1:0]   w_paddr;
    logic                w_uncached;

    // On a tie the requester that did not win last time goes first.
    assign w_grant_inst = bus.inst_req && (!bus.data_req || r_last_grant == OWN_DATA);
    assign w_grant_data = bus.data_req && (!bus.inst_req || r_last_grant == OWN_INST);
    assign w_vaddr      = w_grant_data ? bus.data_addr : bus.inst_addr;

    mem_arbiter_mmu #(.ADDR_W(ADDR_W)) u_mmu (
        .i_vaddr    (w_vaddr),
        .o_paddr    (w_paddr),
        .o_uncached (w_uncached)
    );

    // rst gates the accept strobes so every output is 0 while reset is held.
    assign w_idle      = (r_state == ST_IDLE) && !rst;
    assign w_resp_inst = (r_state == ST_RESP) && (r_owner == OWN_INST);
    assign w_resp_data = (r_state == ST_RESP) && (r_owner == OWN_DATA);

    assign bus.inst_addr_ok = w_idle && w_grant_inst;
    assign bus.data_addr_ok = w_idle && w_grant_data;
    assign bus.inst_data_ok = w_resp_inst && bus.mem_data_ok;
    assign bus.data_data_ok = w_resp_data && bus.mem_data_ok;
    assign bus.inst_rdata   = w_resp_inst ? bus.mem_rdata : '0;
    assign bus.data_rdata   = w_resp_data ? bus.mem_rdata : '0;

    assign bus.mem_req      = r_mem_req;
    assign bus.mem_wr       = r_wr;
    assign bus.mem_size     = r_size;
    assign bus.mem_wstrb    = r_wstrb;
    assign bus.mem_addr     = r_addr;
    assign bus.mem_wdata    = r_wdata;
    assign bus.mem_uncached = r_uncached;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_owner      <= OWN_INST;
            r_last_grant <= OWN_INST;
            r_mem_req    <= 1'b0;
            r_wr         <= 1'b0;
            r_size       <= 2'd0;
            r_wstrb      <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_uncached   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_inst || w_grant_data) begin
                        r_owner      <= w_grant_data ? OWN_DATA : OWN_INST;
                        r_last_grant <= w_grant_data ? OWN_DATA : OWN_INST;
                        r_mem_req    <= 1'b1;
                        r_addr       <= w_paddr;
                        r_uncached   <= w_uncached;
                        if (w_grant_data) begin
                            r_wr    <= bus.data_wr;
                            r_size  <= bus.data_size;
                            r_wstrb <= bus.data_wstrb;
                            r_wdata <= bus.data_wdata;
                        end else begin
                            r_wr    <= 1'b0;
                            r_size  <= SZ_WORD;
                            r_wstrb <= '0;
                            r_wdata <= '0;
                        end
                        r_state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus.mem_addr_ok) begin
                        r_mem_req <= 1'b0;
                        r_state   <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.mem_data_ok) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int vecs = 0;
    int errs = 0;
    int inst_dok = 0;
    int data_dok = 0;
    int outstanding = 0;
    int overlap_viol = 0;
    int outst_viol = 0;

    // Sampled on the falling edge, away from DUT state updates.
    always @(negedge clk) begin
        if (bus.inst_data_ok) inst_dok <= inst_dok + 1;
        if (bus.data_data_ok) data_dok <= data_dok + 1;
        if (bus.inst_addr_ok && bus.data_addr_ok) overlap_viol <= overlap_viol + 1;
        if (rst) begin
            outstanding <= 0;
        end else begin
            if ((bus.inst_addr_ok || bus.data_addr_ok) && outstanding != 0)
                outst_viol <= outst_viol + 1;
            outstanding <= outstanding
                         + ((bus.inst_addr_ok || bus.data_addr_ok) ? 1 : 0)
                         - ((bus.inst_data_ok || bus.data_data_ok) ? 1 : 0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered one step after the accept edge (state REQ). Holds mem_addr_ok
    // off for 'delay' cycles, pulsing stray mem_data_ok meanwhile, then
    // completes the response and returns one step into IDLE.
    task automatic run_mem(input int delay, input logic [31:0] e_addr, input logic e_unc,
                           input logic e_wr, input logic [1:0] e_size, input logic [3:0] e_wstrb,
                           input logic [31:0] e_wdata, input logic e_data_owner,
                           input logic [31:0] rd);
        for (int i = 0; i <= delay; i++) begin
            chk("req_mem_req", bus.mem_req, 1);
            chk("req_mem_addr", bus.mem_addr, e_addr);
            chk("req_uncached", bus.mem_uncached, e_unc);
            chk("req_wr", bus.mem_wr, e_wr);
            chk("req_size", bus.mem_size, e_size);
            chk("req_wstrb", bus.mem_wstrb, e_wstrb);
            chk("req_wdata", bus.mem_wdata, e_wdata);
            chk("req_no_addr_ok", {bus.inst_addr_ok, bus.data_addr_ok}, 0);
            chk("req_no_data_ok", {bus.inst_data_ok, bus.data_data_ok}, 0);
            bus.mem_data_ok = (i < delay);
            bus.mem_addr_ok = (i == delay);
            step();
        end
        bus.mem_addr_ok = 1'b0;
        chk("resp_mem_req_drop", bus.mem_req, 0);
        bus.mem_data_ok = 1'b1;
        bus.mem_rdata   = rd;
        #1;
        if (e_data_owner) begin
            chk("resp_data_ok", bus.data_data_ok, 1);
            chk("resp_data_rdata", bus.data_rdata, rd);
            chk("resp_inst_ok_idle", bus.inst_data_ok, 0);
        end else begin
            chk("resp_inst_ok", bus.inst_data_ok, 1);
            chk("resp_inst_rdata", bus.inst_rdata, rd);
            chk("resp_data_ok_idle", bus.data_data_ok, 0);
        end
        step();
        bus.mem_data_ok = 1'b0;
        bus.mem_rdata   = 32'h0;
    endtask

    initial begin
        bus.inst_req    = 1'b1;
        bus.inst_addr   = 32'hBFC0_0000;
        bus.data_req    = 1'b1;
        bus.data_wr     = 1'b0;
        bus.data_size   = 2'd2;
        bus.data_wstrb  = 4'h0;
        bus.data_addr   = 32'h0040_0000;
        bus.data_wdata  = 32'h0;
        bus.mem_addr_ok = 1'b0;
        bus.mem_data_ok = 1'b0;
        bus.mem_rdata   = 32'h0;

        #2;
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_addr_ok", {bus.inst_addr_ok, bus.data_addr_ok}, 0);
        chk("rst_data_ok", {bus.inst_data_ok, bus.data_data_ok}, 0);

        // Tie from reset: data first (load 0x00400000), then fetch 0xBFC00000.
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("tie1_data_addr_ok", bus.data_addr_ok, 1);
        chk("tie1_inst_addr_ok", bus.inst_addr_ok, 0);
        step();
        bus.data_req = 1'b0;
        run_mem(0, 32'h0040_0000, 1'b0, 1'b0, 2'd2, 4'h0, 32'h0, 1'b1, 32'h1111_2222);
        chk("tie2_inst_addr_ok", bus.inst_addr_ok, 1);
        chk("tie2_data_addr_ok", bus.data_addr_ok, 0);
        step();
        bus.inst_req = 1'b0;
        run_mem(0, 32'h1FC0_0000, 1'b1, 1'b0, 2'd2, 4'h0, 32'h0, 1'b0, 32'h3C1D_A000);
        chk("fetch_pulses", inst_dok, 1);
        chk("load_pulses", data_dok, 1);

        // Store word to kseg0.
        bus.data_req   = 1'b1;
        bus.data_wr    = 1'b1;
        bus.data_addr  = 32'h8000_1234;
        bus.data_wstrb = 4'hF;
        bus.data_wdata = 32'hDEAD_BEEF;
        #1;
        chk("store_addr_ok", bus.data_addr_ok, 1);
        step();
        bus.data_req = 1'b0;
        run_mem(0, 32'h0000_1234, 1'b0, 1'b1, 2'd2, 4'hF, 32'hDEAD_BEEF, 1'b1, 32'h0);
        chk("store_pulses", data_dok, 2);

        // Tie after a data grant: fetch wins; mem_addr_ok delayed 3 cycles.
        bus.inst_req   = 1'b1;
        bus.inst_addr  = 32'h0000_1000;
        bus.data_req   = 1'b1;
        bus.data_wr    = 1'b0;
        bus.data_size  = 2'd0;
        bus.data_wstrb = 4'h0;
        bus.data_wdata = 32'h0;
        bus.data_addr  = 32'hA000_0010;
        #1;
        chk("tie3_inst_addr_ok", bus.inst_addr_ok, 1);
        chk("tie3_data_addr_ok", bus.data_addr_ok, 0);
        step();
        bus.inst_req = 1'b0;
        run_mem(3, 32'h0000_1000, 1'b0, 1'b0, 2'd2, 4'h0, 32'h0, 1'b0, 32'h55AA_55AA);
        chk("kseg1_load_addr_ok", bus.data_addr_ok, 1);
        step();
        bus.data_req = 1'b0;
        run_mem(0, 32'h0000_0010, 1'b1, 1'b0, 2'd0, 4'h0, 32'h0, 1'b1, 32'h0000_00AB);
        chk("delay_inst_pulses", inst_dok, 2);
        chk("delay_data_pulses", data_dok, 3);

        // Reset while in RESP.
        bus.inst_req  = 1'b1;
        bus.inst_addr = 32'h9FC0_0000;
        #1;
        chk("rr_addr_ok", bus.inst_addr_ok, 1);
        step();
        bus.inst_req = 1'b0;
        chk("rr_mem_addr", bus.mem_addr, 32'h1FC0_0000);
        chk("rr_uncached", bus.mem_uncached, 0);
        bus.mem_addr_ok = 1'b1;
        step();
        bus.mem_addr_ok = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk("rr_async_mem_addr", bus.mem_addr, 0);
        chk("rr_async_mem_size", bus.mem_size, 0);
        chk("rr_async_mem_req", bus.mem_req, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.mem_data_ok = 1'b1;
        bus.mem_rdata   = 32'hCAFE_F00D;
        #1;
        chk("rr_stale_inst_ok", bus.inst_data_ok, 0);
        chk("rr_stale_inst_rdata", bus.inst_rdata, 0);
        chk("rr_stale_data_ok", bus.data_data_ok, 0);
        step();
        bus.mem_data_ok = 1'b0;
        bus.mem_rdata   = 32'h0;
        chk("rr_stale_pulses", inst_dok, 2);

        // Fresh tie after reset: data again first, then fetch.
        bus.data_req   = 1'b1;
        bus.data_wr    = 1'b1;
        bus.data_size  = 2'd1;
        bus.data_wstrb = 4'hC;
        bus.data_addr  = 32'h7FFF_FFFC;
        bus.data_wdata = 32'h1234_5678;
        bus.inst_req   = 1'b1;
        bus.inst_addr  = 32'hBFC0_0004;
        #1;
        chk("post_rst_data_addr_ok", bus.data_addr_ok, 1);
        chk("post_rst_inst_addr_ok", bus.inst_addr_ok, 0);
        step();
        bus.data_req = 1'b0;
        run_mem(0, 32'h7FFF_FFFC, 1'b0, 1'b1, 2'd1, 4'hC, 32'h1234_5678, 1'b1, 32'h0);
        chk("post_rst_inst_addr_ok2", bus.inst_addr_ok, 1);
        step();
        bus.inst_req = 1'b0;
        run_mem(1, 32'h1FC0_0004, 1'b1, 1'b0, 2'd2, 4'h0, 32'h0, 1'b0, 32'h2408_0001);

        #1;
        chk("final_inst_pulses", inst_dok, 3);
        chk("final_data_pulses", data_dok, 4);
        chk("addr_ok_overlap", overlap_viol, 0);
        chk("outstanding_gt1", outst_viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
